// File: rtl/rb1_arb_if.sv
// Port bundle for rb1_arb: two requester ports (0 = serial framer, 1 = host)
// plus the single-ported register-bank bus the arbiter drives.
interface rb1_arb_if;
  logic       req0;
  logic       rw0;
  logic [4:0] a0;
  logic [7:0] d0;
  logic       gnt0;
  logic [7:0] q0;
  logic       qv0;

  logic       req1;
  logic       rw1;
  logic [4:0] a1;
  logic [7:0] d1;
  logic       gnt1;
  logic [7:0] q1;
  logic       qv1;

  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q;

  modport slave (
    input  req0, rw0, a0, d0, req1, rw1, a1, d1, RB1_Q,
    output gnt0, q0, qv0, gnt1, q1, qv1, RB1_RW, RB1_A, RB1_D
  );

  modport master (
    output req0, rw0, a0, d0, req1, rw1, a1, d1, RB1_Q,
    input  gnt0, q0, qv0, gnt1, q1, qv1, RB1_RW, RB1_A, RB1_D
  );
endinterface

// File: rtl/rb1_arb.sv
// Two-port arbiter onto a single register bank with 2-cycle read return.
// Define RB1_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module rb1_arb (
  input  logic      clk,
  input  logic      rst,
  rb1_arb_if.slave  bus
);

  typedef struct packed {
    logic vld;
    logic port;
  } tag_t;

  logic       gnt0;
  logic       gnt1;
  logic       xfer;
  logic       sel;
  logic       c_rw;
  logic [4:0] c_a;
  logic [7:0] c_d;

  logic       rw_q, rw_d;
  logic [4:0] a_q,  a_d;
  logic [7:0] d_q,  d_d;
  tag_t       tag1_q, tag1_d;
  tag_t       tag2_q, tag2_d;
  logic [7:0] q0_q, q0_d;
  logic [7:0] q1_q, q1_d;
  logic       qv0_q, qv0_d;
  logic       qv1_q, qv1_d;

`ifndef RB1_ARB_FIXED_PRIO_EN
  // Port that won the most recent transfer; reset to 1 so port 0 wins first contention.
  logic       last_q, last_d;
`endif

  // Grants are combinational so a lone requester is served in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
`ifdef RB1_ARB_FIXED_PRIO_EN
      gnt0 = bus.req0;
      gnt1 = bus.req1 & ~bus.req0;
`else
      if (bus.req0 && bus.req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
`endif
    end
  end

  assign xfer = gnt0 | gnt1;
  assign sel  = gnt1;
  assign c_rw = sel ? bus.rw1 : bus.rw0;
  assign c_a  = sel ? bus.a1  : bus.a0;
  assign c_d  = sel ? bus.d1  : bus.d0;

  always_comb begin
    rw_d   = 1'b1;
    a_d    = a_q;
    d_d    = d_q;
    if (xfer) begin
      rw_d = c_rw;
      a_d  = c_a;
      d_d  = c_d;
    end

    // Read tags ride two stages: bank samples in stage 1, data returns in stage 2.
    tag1_d = '{vld: xfer & c_rw, port: sel};
    tag2_d = tag1_q;

    qv0_d  = tag2_q.vld & ~tag2_q.port;
    qv1_d  = tag2_q.vld &  tag2_q.port;
    q0_d   = qv0_d ? bus.RB1_Q : q0_q;
    q1_d   = qv1_d ? bus.RB1_Q : q1_q;

`ifndef RB1_ARB_FIXED_PRIO_EN
    last_d = xfer ? sel : last_q;
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q   <= 1'b1;
      a_q    <= 5'h00;
      d_q    <= 8'h00;
      tag1_q <= '0;
      tag2_q <= '0;
      q0_q   <= 8'h00;
      q1_q   <= 8'h00;
      qv0_q  <= 1'b0;
      qv1_q  <= 1'b0;
`ifndef RB1_ARB_FIXED_PRIO_EN
      last_q <= 1'b1;
`endif
    end else begin
      rw_q   <= rw_d;
      a_q    <= a_d;
      d_q    <= d_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      q0_q   <= q0_d;
      q1_q   <= q1_d;
      qv0_q  <= qv0_d;
      qv1_q  <= qv1_d;
`ifndef RB1_ARB_FIXED_PRIO_EN
      last_q <= last_d;
`endif
    end
  end

  assign bus.gnt0   = gnt0;
  assign bus.gnt1   = gnt1;
  assign bus.q0     = q0_q;
  assign bus.q1     = q1_q;
  assign bus.qv0    = qv0_q;
  assign bus.qv1    = qv1_q;
  assign bus.RB1_RW = rw_q;
  assign bus.RB1_A  = a_q;
  assign bus.RB1_D  = d_q;

endmodule

// File: tb/tb_rb1_arb.sv
// Self-checking bench for rb1_arb: directed scenarios then random traffic,
// checked against a transaction-level model (grant rule, memory image, return queue).
module tb_rb1_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rb1_arb_if bus ();

  rb1_arb u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 31) return 8'h3C;
    return 8'(i * 8'h11 + 8'h07);
  endfunction

  // Behavioural register bank: write on the edge, read data valid the next cycle.
  logic [7:0] bank [32];
  bit         bank_init = 1'b0;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
      bank_init <= 1'b1;
      bus.RB1_Q <= 8'h00;
    end else begin
      if (!bus.RB1_RW) bank[bus.RB1_A] <= bus.RB1_D;
      bus.RB1_Q <= bank[bus.RB1_A];
    end
  end

  // Reference model state
  typedef struct {
    int         due;
    bit         port;
    logic [7:0] data;
  } ret_t;

  ret_t       pend[$];
  logic [7:0] mem_m [32];
  bit         last_m;
  int         cyc;
  logic       exp_rw, exp_qv0, exp_qv1;
  logic [4:0] exp_a;
  logic [7:0] exp_d, exp_q0, exp_q1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      $error("assertion %s", tag);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_rb1_rw"}, 8'(bus.RB1_RW), 8'(exp_rw));
    check({tag, "_rb1_a"},  8'(bus.RB1_A),  8'(exp_a));
    check({tag, "_rb1_d"},  bus.RB1_D,      exp_d);
    check({tag, "_qv0"},    8'(bus.qv0),    8'(exp_qv0));
    check({tag, "_qv1"},    8'(bus.qv1),    8'(exp_qv1));
    check({tag, "_q0"},     bus.q0,         exp_q0);
    check({tag, "_q1"},     bus.q1,         exp_q1);
  endtask

  // One clock of traffic: drive at the falling edge, check grants, then registered outputs.
  task automatic cycle(input string tag,
                       input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1);
    bit         eg0, eg1, p;
    logic       rw;
    logic [4:0] a;
    logic [7:0] d;
    bus.req0 = r0; bus.rw0 = w0; bus.a0 = a0; bus.d0 = d0;
    bus.req1 = r1; bus.rw1 = w1; bus.a1 = a1; bus.d1 = d1;
    if (r0 && r1) begin
`ifdef RB1_ARB_FIXED_PRIO_EN
      eg0 = 1'b1;
`else
      eg0 = (last_m == 1'b1);
`endif
      eg1 = ~eg0;
    end else begin
      eg0 = r0;
      eg1 = r1;
    end
    #1;
    check({tag, "_gnt0"}, 8'(bus.gnt0), 8'(eg0));
    check({tag, "_gnt1"}, 8'(bus.gnt1), 8'(eg1));
    @(posedge clk);
    cyc++;
    exp_rw = 1'b1;
    if (eg0 || eg1) begin
      p  = eg1;
      rw = p ? w1 : w0;
      a  = p ? a1 : a0;
      d  = p ? d1 : d0;
      exp_rw = rw;
      exp_a  = a;
      exp_d  = d;
      if (rw) pend.push_back('{due: cyc + 2, port: p, data: mem_m[a]});
      else    mem_m[a] = d;
      last_m = p;
    end
    exp_qv0 = 1'b0;
    exp_qv1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) begin exp_qv1 = 1'b1; exp_q1 = pend[0].data; end
      else              begin exp_qv0 = 1'b1; exp_q0 = pend[0].data; end
      void'(pend.pop_front());
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) cycle(tag, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
  endtask

  // Asserts reset at the current falling edge, holds it n cycles, then releases.
  task automatic apply_reset(input string tag, input int n);
    rst = 1'b0;
    pend.delete();
    last_m  = 1'b1;
    exp_rw  = 1'b1; exp_a = 5'h00; exp_d = 8'h00;
    exp_qv0 = 1'b0; exp_qv1 = 1'b0; exp_q0 = 8'h00; exp_q1 = 8'h00;
    #1;
    check({tag, "_gnt0"}, 8'(bus.gnt0), 8'h00);
    check({tag, "_gnt1"}, 8'(bus.gnt1), 8'h00);
    check_regs(tag);
    repeat (n) begin
      @(negedge clk);
      check({tag, "_gnt0_hold"}, 8'(bus.gnt0), 8'h00);
      check_regs({tag, "_hold"});
    end
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_m[i] = init_val(i);
    cyc = 0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.a0 = 5'h07; bus.d0 = 8'h55;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.a1 = 5'h09; bus.d1 = 8'h66;
    @(negedge clk);

    // Reset values with both ports requesting
    apply_reset("reset", 2);

    // Write then read-after-write on port 0
    cycle("wr_a5", 1'b1, 1'b0, 5'h03, 8'hA5, 1'b0, 1'b0, 5'h00, 8'h00);
    cycle("rd_a5", 1'b1, 1'b1, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
    idle("raw_ret", 3);
    check("raw_q0_const", bus.q0, 8'hA5);

    // Contention from reset: round-robin alternation and in-order returns
    @(negedge clk);
    apply_reset("reset2", 1);
    repeat (4) cycle("contend", 1'b1, 1'b1, 5'h03, 8'h11, 1'b1, 1'b1, 5'h05, 8'h22);
    idle("contend_ret", 3);

    // Lone port 1 read of the preloaded location
    cycle("p1_rd", 1'b0, 1'b1, 5'h1F, 8'hFF, 1'b1, 1'b1, 5'h1F, 8'h00);
    idle("p1_ret", 3);
    check("p1_q1_const", bus.q1, 8'h3C);

    // Read in flight discarded by reset
    cycle("rd_then_rst", 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h02, 8'h00);
    apply_reset("mid_rst", 1);
    idle("after_rst", 4);

    // Random traffic on a narrow address range to exercise write/read hazards
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 8'($urandom));
    end
    idle("drain", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
